// File: rtl/mcp_pkg.sv
// Shared types and defaults for the MCP transmit/capture pair.
package mcp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        WAIT = 2'd2
    } mcp_tx_state_e;

    localparam int MCP_DATA_W      = 8;
    localparam int MCP_SYNC_STAGES = 2;

endpackage

// File: rtl/mcp_sync.sv
// Flop-chain synchronizer with synchronous reset to 0; o_q_pre is the stage
// feeding the output flop, so o_q changes on the next edge when they differ.
module mcp_sync #(
    parameter int STAGES = mcp_pkg::MCP_SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q,
    output logic o_q_pre
);

    logic [STAGES-1:0] r_chain;

    // shift chain, cleared by synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q     = r_chain[STAGES-1];
    assign o_q_pre = r_chain[STAGES-2];

endmodule

// File: rtl/mcp_tx.sv
// Multicycle-path transmit stage: holds a word stable, toggles mcp_req, waits for
// the synchronized toggle ack. Optional even parity output under MCP_TX_PARITY_EN.
module mcp_tx
    import mcp_pkg::*;
#(
    parameter int WIDTH       = MCP_DATA_W,
    parameter int MIN_HOLD    = 2,
    parameter int SYNC_STAGES = MCP_SYNC_STAGES
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] mcp_data,
    output logic             mcp_req,
    input  logic             mcp_ack,
    output logic             busy,
    output logic             ack_err
`ifdef MCP_TX_PARITY_EN
    ,
    output logic             mcp_parity
`endif
);

    localparam int CNT_W = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MIN_HOLD - 1);

    mcp_tx_state_e    r_state;
    mcp_tx_state_e    w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_req;
    logic             r_busy;
    logic             r_in_ready;
    logic             r_ack_err;
    logic             w_load;
    logic             w_toggle;
    logic             w_ack_s;
    logic             w_ack_pre;

    mcp_sync #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .i_clk   (clk1),
        .i_reset (reset),
        .i_d     (mcp_ack),
        .o_q     (w_ack_s),
        .o_q_pre (w_ack_pre)
    );

    // next-state and transfer strobes
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_toggle    = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = HOLD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (r_cnt == CNT_LAST) begin
                    w_toggle    = 1'b1;
                    w_state_nxt = WAIT;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            WAIT: begin
                if (w_ack_s == r_req) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // state, held word, request toggle and status flags
    always_ff @(posedge clk1) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_data     <= '0;
            r_req      <= 1'b0;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
            r_ack_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= (w_state_nxt != IDLE);
            r_in_ready <= (w_state_nxt == IDLE);
            if (w_load) begin
                r_data <= in_data;
                r_cnt  <= '0;
            end else if (r_state == HOLD && r_cnt != CNT_LAST) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_toggle) begin
                r_req <= ~r_req;
            end
            // ack_s is about to change on this edge; only legal while waiting
            if (r_state != WAIT && w_ack_pre != w_ack_s) begin
                r_ack_err <= 1'b1;
            end
        end
    end

`ifdef MCP_TX_PARITY_EN
    logic r_parity;

    // parity captured alongside the data word
    always_ff @(posedge clk1) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^in_data;
        end
    end

    assign mcp_parity = r_parity;
`endif

    assign in_ready = r_in_ready;
    assign mcp_data = r_data;
    assign mcp_req  = r_req;
    assign busy     = r_busy;
    assign ack_err  = r_ack_err;

endmodule

// File: tb/tb_mcp_tx.sv
// Directed bench for mcp_tx with hand-computed expectations.
module tb_mcp_tx;

    logic       clk1 = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] mcp_data;
    logic       mcp_req;
    logic       mcp_ack;
    logic       busy;
    logic       ack_err;
`ifdef MCP_TX_PARITY_EN
    logic       mcp_parity;
`endif
    logic       loop_en;
    logic       ack_manual;

    int total = 0;
    int bad   = 0;

    assign mcp_ack = loop_en ? mcp_req : ack_manual;

    always #5 clk1 = ~clk1;

    mcp_tx dut (
        .clk1     (clk1),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mcp_data (mcp_data),
        .mcp_req  (mcp_req),
        .mcp_ack  (mcp_ack),
        .busy     (busy),
        .ack_err  (ack_err)
`ifdef MCP_TX_PARITY_EN
        ,
        .mcp_parity (mcp_parity)
`endif
    );

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 8'h55;
        loop_en = 1'b0; ack_manual = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (mcp_data !== 8'h00) begin bad++; $display("FAIL reset_nocapture got %h want 00", mcp_data); end
        end
        reset = 1'b0; in_valid = 1'b0;
        total++; if (mcp_req !== 1'b0) begin bad++; $display("FAIL reset_req got %b want 0", mcp_req); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", ack_err); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", in_ready); end
`ifdef MCP_TX_PARITY_EN
        total++; if (mcp_parity !== 1'b0) begin bad++; $display("FAIL reset_parity got %b want 0", mcp_parity); end
`endif
    endtask

    task automatic test_single(input logic [7:0] w, input logic par);
        logic req0;
        loop_en = 1'b1;
        req0 = mcp_req;
        in_data = w; in_valid = 1'b1;
        tick();  // E0
        in_valid = 1'b0;
        total++; if (mcp_data !== w) begin bad++; $display("FAIL single_data got %h want %h", mcp_data, w); end
        total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL single_busy got %b/%b want 1/0", busy, in_ready); end
`ifdef MCP_TX_PARITY_EN
        total++; if (mcp_parity !== par) begin bad++; $display("FAIL single_parity got %b want %b", mcp_parity, par); end
`else
        if (par === 1'bx) $display("unused parity argument");
`endif
        tick();  // E0+1
        total++; if (mcp_req !== req0) begin bad++; $display("FAIL single_req_early got %b want %b", mcp_req, req0); end
        tick();  // E0+2
        total++; if (mcp_req !== ~req0) begin bad++; $display("FAIL single_req_toggle got %b want %b", mcp_req, ~req0); end
        tick(); tick();  // E0+4
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL single_ready_early got %b want 0", in_ready); end
        tick();  // E0+5
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL single_done got %b/%b want 1/0", in_ready, busy); end
        total++; if (mcp_data !== w) begin bad++; $display("FAIL single_hold got %h want %h", mcp_data, w); end
    endtask

    task automatic test_stream();
        logic [7:0] words [6];
        logic       prev_req;
        int         toggles;
        words = '{8'd10, 8'd10, 8'd20, 8'd60, 8'd240, 8'd176};
        loop_en = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_data = words[k];
            prev_req = mcp_req;
            toggles = 0;
            for (int c = 0; c < 6; c++) begin
                tick();
                if (k == 5 && c == 0) in_valid = 1'b0;
                if (mcp_req !== prev_req) toggles++;
                prev_req = mcp_req;
                total++;
                if (mcp_data !== words[k]) begin bad++; $display("FAIL stream_data w%0d c%0d got %h want %h", k, c, mcp_data, words[k]); end
            end
            total++; if (toggles != 1) begin bad++; $display("FAIL stream_toggles w%0d got %0d want 1", k, toggles); end
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_period w%0d got ready %b want 1", k, in_ready); end
        end
    endtask

    task automatic test_stall();
        ack_manual = mcp_req;
        loop_en = 1'b0;
        in_data = 8'h5A; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        tick(); tick();  // req toggled, now in WAIT
        for (int i = 0; i < 50; i++) begin
            tick();
            total++;
            if (mcp_data !== 8'h5A || in_ready !== 1'b0 || busy !== 1'b1) begin
                bad++; $display("FAIL stall c%0d got data %h ready %b busy %b want 5a 0 1", i, mcp_data, in_ready, busy);
            end
        end
        ack_manual = mcp_req;
        tick(); tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_release_early got %b want 0", in_ready); end
        tick();
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL stall_release got %b/%b want 1/0", in_ready, busy); end
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL stall_err got %b want 0", ack_err); end
    endtask

    task automatic test_ack_err();
        loop_en = 1'b0;
        ack_manual = ~ack_manual;
        tick();
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL err_early got %b want 0", ack_err); end
        tick();
        total++; if (ack_err !== 1'b1) begin bad++; $display("FAIL err_set got %b want 1", ack_err); end
        ack_manual = ~ack_manual;
        for (int i = 0; i < 5; i++) tick();
        total++; if (ack_err !== 1'b1) begin bad++; $display("FAIL err_sticky got %b want 1", ack_err); end
        reset = 1'b1; ack_manual = 1'b0;
        tick();
        reset = 1'b0;
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL err_clear got %b want 0", ack_err); end
    endtask

    task automatic test_reset_mid();
        loop_en = 1'b1;
        in_data = 8'h3C; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        tick();
        total++; if (mcp_data !== 8'h3C || busy !== 1'b1) begin bad++; $display("FAIL mid_pre got %h/%b want 3c/1", mcp_data, busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (mcp_data !== 8'h00) begin bad++; $display("FAIL mid_data got %h want 00", mcp_data); end
        total++; if (mcp_req !== 1'b0) begin bad++; $display("FAIL mid_req got %b want 0", mcp_req); end
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mid_idle got %b/%b want 1/0", in_ready, busy); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        loop_en = 1'b0; ack_manual = 1'b0;
        #2;
        test_reset();
        test_single(8'h0A, 1'b0);
        test_single(8'h07, 1'b1);
        test_stream();
        test_stall();
        test_ack_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
